// File: rtl/nonce_search_ctrl_pkg.sv
// Shared widths, FSM state codes and the win-compare rule for the nonce search path.
package nonce_search_ctrl_pkg;

   localparam int ENTRY_W  = 96;
   localparam int NONCE_W  = 32;
   localparam int TARGET_W = 8;
   localparam int HASH_W   = 24;

   // Byte of the hash compared against the target; micro_hash benches reuse this.
   localparam int WIN_HI = 23;
   localparam int WIN_LO = 16;

   localparam int ST_W = 3;
   typedef logic [ST_W-1:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_LOAD    = 3'd1;
   localparam state_t ST_WAIT    = 3'd2;
   localparam state_t ST_CHECK   = 3'd3;
   localparam state_t ST_RELEASE = 3'd4;
   localparam state_t ST_END     = 3'd5;

   function automatic logic hash_wins(input logic [HASH_W-1:0]   h,
                                      input logic [TARGET_W-1:0] t);
      return h[WIN_HI:WIN_LO] < t;
   endfunction

endpackage

// File: rtl/nonce_search_ctrl_if.sv
// Controller <-> concatenator / micro_hash bundle.
interface nonce_search_ctrl_if;
   import nonce_search_ctrl_pkg::*;

   logic                selector;
   logic [ENTRY_W-1:0]  data_entry_12;
   logic [NONCE_W-1:0]  data_nonce;
   logic [TARGET_W-1:0] data_target;
   logic                hash_done;
   logic [HASH_W-1:0]   H_out;

   // Search controller side.
   modport master (
      output selector, data_entry_12, data_nonce, data_target,
      input  hash_done, H_out
   );

   // Concatenator / hash core side.
   modport slave (
      input  selector, data_entry_12, data_nonce, data_target,
      output hash_done, H_out
   );

endinterface

// File: rtl/nonce_search_ctrl_timeout_cnt.sv
// Per-nonce watchdog: down-counter loaded with the cycle budget, terminal at zero.
module nonce_timeout_cnt #(
   parameter int             W        = 8,
   parameter logic [W-1:0]   LOAD_VAL = '0
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic term
);

   logic [W-1:0] cnt_q, cnt_d;

   // Load has priority; decrement parks at zero so term stays asserted.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign term = (cnt_q == '0);

endmodule

// File: rtl/nonce_search_ctrl.sv
// Nonce sweep controller: presents candidates to the concatenator, consumes
// micro_hash results and stops on a win, range exhaustion or hash timeout.
//
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   LOAD    | present current nonce, arm watchdog
//   WAIT    | selector high, waiting for hash_done
//   CHECK   | compare captured hash against target
//   RELEASE | selector low, waiting for hash_done to drop
//   END     | results held, waiting for a new start
module nonce_search_ctrl
   import nonce_search_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ENTRY_W-1:0]   entry_12_in,
   input  logic [TARGET_W-1:0]  target_in,
   input  logic [NONCE_W-1:0]   nonce_first,
   input  logic [NONCE_W-1:0]   nonce_last,
   nonce_search_ctrl_if.master  hif,
   output logic                 busy,
   output logic                 found,
   output logic                 done,
   output logic                 timeout,
   output logic [NONCE_W-1:0]   nonce_out,
   output logic [HASH_W-1:0]    hash_out,
   output logic [31:0]          attempts
);

   state_t              state_q,     state_d;
   logic [ENTRY_W-1:0]  entry_q,     entry_d;
   logic [TARGET_W-1:0] target_q,    target_d;
   logic [NONCE_W-1:0]  nonce_q,     nonce_d;
   logic [NONCE_W-1:0]  last_q,      last_d;
   logic                sel_q,       sel_d;
   logic                found_q,     found_d;
   logic                done_q,      done_d;
   logic                timeout_q,   timeout_d;
   logic [NONCE_W-1:0]  nonce_out_q, nonce_out_d;
   logic [HASH_W-1:0]   hash_out_q,  hash_out_d;
   logic [31:0]         attempts_q,  attempts_d;

   logic cnt_load, cnt_en, cnt_term;

   // Budget of TIMEOUT_CYCLES WAIT cycles: terminal count is seen on the last one.
   nonce_timeout_cnt #(
      .W        (TO_W),
      .LOAD_VAL (TO_W'(TIMEOUT_CYCLES - 1))
   ) u_timeout_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (cnt_load),
      .en    (cnt_en),
      .term  (cnt_term)
   );

   // Next-state and datapath decode.
   always_comb begin
      state_d     = state_q;
      entry_d     = entry_q;
      target_d    = target_q;
      nonce_d     = nonce_q;
      last_d      = last_q;
      found_d     = found_q;
      done_d      = done_q;
      timeout_d   = timeout_q;
      nonce_out_d = nonce_out_q;
      hash_out_d  = hash_out_q;
      attempts_d  = attempts_q;
      cnt_load    = 1'b0;
      cnt_en      = 1'b0;

      case (state_q)
         ST_IDLE, ST_END: begin
            if (start) begin
               entry_d    = entry_12_in;
               target_d   = target_in;
               nonce_d    = nonce_first;
               last_d     = nonce_last;
               found_d    = 1'b0;
               done_d     = 1'b0;
               timeout_d  = 1'b0;
               attempts_d = '0;
               if (nonce_first > nonce_last) begin
                  done_d  = 1'b1;
                  state_d = ST_END;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            cnt_load = 1'b1;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_en = 1'b1;
            // A result arriving on the last budget cycle still counts.
            if (hif.hash_done) begin
               hash_out_d = hif.H_out;
               if (attempts_q != '1) attempts_d = attempts_q + 32'd1;
               state_d = ST_CHECK;
            end else if (cnt_term) begin
               timeout_d = 1'b1;
               done_d    = 1'b1;
               state_d   = ST_END;
            end
         end
         ST_CHECK: begin
            if (hash_wins(hash_out_q, target_q)) begin
               nonce_out_d = nonce_q;
               found_d     = 1'b1;
               done_d      = 1'b1;
               state_d     = ST_END;
            end else if (nonce_q == last_q) begin
               nonce_out_d = last_q;
               done_d      = 1'b1;
               state_d     = ST_END;
            end else begin
               nonce_d = nonce_q + 32'd1;
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            cnt_en = 1'b1;
            // A core that never drops hash_done is treated as hung.
            if (!hif.hash_done) begin
               state_d = ST_LOAD;
            end else if (cnt_term) begin
               timeout_d = 1'b1;
               done_d    = 1'b1;
               state_d   = ST_END;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      sel_d = (state_d == ST_LOAD) || (state_d == ST_WAIT) || (state_d == ST_CHECK);
   end

   // State and result registers; async reset aborts any search silently.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         entry_q     <= '0;
         target_q    <= '0;
         nonce_q     <= '0;
         last_q      <= '0;
         sel_q       <= 1'b0;
         found_q     <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         nonce_out_q <= '0;
         hash_out_q  <= '0;
         attempts_q  <= '0;
      end else begin
         state_q     <= state_d;
         entry_q     <= entry_d;
         target_q    <= target_d;
         nonce_q     <= nonce_d;
         last_q      <= last_d;
         sel_q       <= sel_d;
         found_q     <= found_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         nonce_out_q <= nonce_out_d;
         hash_out_q  <= hash_out_d;
         attempts_q  <= attempts_d;
      end
   end

   assign hif.selector      = sel_q;
   assign hif.data_entry_12 = entry_q;
   assign hif.data_nonce    = nonce_q;
   assign hif.data_target   = target_q;

   assign busy      = (state_q != ST_IDLE) && (state_q != ST_END);
   assign found     = found_q;
   assign done      = done_q;
   assign timeout   = timeout_q;
   assign nonce_out = nonce_out_q;
   assign hash_out  = hash_out_q;
   assign attempts  = attempts_q;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Bench for nonce_search_ctrl: behavioural hash core plus a sweep-level reference.
module tb_nonce_search_ctrl;
   import nonce_search_ctrl_pkg::*;

   localparam int TIMEOUT_CYCLES = 255;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                start = 1'b0;
   logic [ENTRY_W-1:0]  entry_12_in = '0;
   logic [TARGET_W-1:0] target_in = '0;
   logic [NONCE_W-1:0]  nonce_first = '0;
   logic [NONCE_W-1:0]  nonce_last = '0;
   logic                busy, found, done, timeout;
   logic [NONCE_W-1:0]  nonce_out;
   logic [HASH_W-1:0]   hash_out;
   logic [31:0]         attempts;

   nonce_search_ctrl_if hif();

   nonce_search_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .entry_12_in (entry_12_in),
      .target_in   (target_in),
      .nonce_first (nonce_first),
      .nonce_last  (nonce_last),
      .hif         (hif),
      .busy        (busy),
      .found       (found),
      .done        (done),
      .timeout     (timeout),
      .nonce_out   (nonce_out),
      .hash_out    (hash_out),
      .attempts    (attempts)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Hash table: the top byte depends on the offset from hb_base.
   logic [7:0]  hb [16];
   logic [31:0] hb_base = '0;
   logic [15:0] salt = 16'h5a3c;

   function automatic logic [23:0] model_hash(input logic [31:0] n);
      logic [31:0] off;
      off = n - hb_base;
      return {hb[off[3:0]], n[15:0] ^ salt};
   endfunction

   // Hash core: answers core_lat cycles after selector rises, holds until selector drops.
   bit core_en  = 1'b1;
   int core_lat = 20;

   initial begin : core_model
      int lat_cnt;
      lat_cnt       = 0;
      hif.hash_done = 1'b0;
      hif.H_out     = '0;
      forever begin
         @(negedge clk);
         if (!hif.hash_done) begin
            if (hif.selector && core_en) begin
               lat_cnt++;
               if (lat_cnt >= core_lat) begin
                  hif.H_out     = model_hash(hif.data_nonce);
                  hif.hash_done = 1'b1;
                  lat_cnt       = 0;
               end
            end else begin
               lat_cnt = 0;
            end
         end else if (!hif.selector) begin
            hif.hash_done = 1'b0;
         end
      end
   end

   int sel_rises = 0;
   always @(posedge hif.selector) sel_rises++;

   // Sweep reference: walk the range in order, first winner stops.
   task automatic ref_search(input logic [31:0] f, input logic [31:0] l, input logic [7:0] t,
                             output logic ef, output logic [31:0] en, output logic [31:0] ea);
      logic [23:0] h;
      logic [32:0] n;
      ef = 1'b0;
      en = '0;
      ea = '0;
      if (f > l) return;
      for (n = {1'b0, f}; n <= {1'b0, l}; n++) begin
         ea++;
         h = model_hash(n[31:0]);
         if (h[23:16] < t) begin
            ef = 1'b1;
            en = n[31:0];
            return;
         end
      end
      en = l;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int cycles);
      cycles = 0;
      while (!done && cycles < 20000) begin
         @(negedge clk);
         cycles++;
      end
      if (!done) check({tag, "_wait_budget"}, 0, 1);
   endtask

   task automatic run_search(input string name, input logic [31:0] f, input logic [31:0] l,
                             input logic [7:0] t, input int lat);
      logic [95:0] e;
      logic        ef;
      logic [31:0] en, ea;
      logic [23:0] eh;
      int          cyc;
      e        = {$urandom, $urandom, $urandom};
      core_lat = lat;
      core_en  = 1'b1;
      hb_base  = f;
      ref_search(f, l, t, ef, en, ea);
      entry_12_in = e;
      target_in   = t;
      nonce_first = f;
      nonce_last  = l;
      sel_rises   = 0;
      pulse_start();
      wait_done(name, cyc);
      check({name, "_done"},     done, 1);
      check({name, "_found"},    found, ef);
      check({name, "_attempts"}, attempts, ea);
      check({name, "_timeout"},  timeout, 0);
      check({name, "_busy"},     busy, 0);
      check({name, "_selector"}, hif.selector, 0);
      check({name, "_loads"},    sel_rises, ea);
      check({name, "_entry"},    hif.data_entry_12, e);
      check({name, "_target"},   hif.data_target, t);
      if (f <= l) begin
         eh = model_hash(en);
         check({name, "_nonce_out"}, nonce_out, en);
         check({name, "_hash_out"},  hash_out, eh);
      end
   endtask

   initial begin
      int          cyc;
      logic [31:0] f, l;
      int          len;

      // Reset values
      #12;
      check("rst_busy", busy, 0);
      check("rst_found", found, 0);
      check("rst_done", done, 0);
      check("rst_selector", hif.selector, 0);
      check("rst_nonce", hif.data_nonce, 0);
      check("rst_attempts", attempts, 0);
      @(negedge clk);
      reset = 1'b1;

      // Immediate win on first nonce
      for (int i = 0; i < 16; i++) hb[i] = 8'($urandom);
      hb[0] = 8'h10;
      run_search("tp1", 32'd5, 32'd9, 8'h20, 20);

      // Win on the fourth nonce
      for (int i = 0; i < 16; i++) hb[i] = 8'($urandom);
      hb[0] = 8'hFF; hb[1] = 8'hFF; hb[2] = 8'hFF; hb[3] = 8'h01;
      run_search("tp2", 32'd0, 32'd10, 8'h05, 7);

      // Exhausted range
      for (int i = 0; i < 16; i++) hb[i] = 8'hFF;
      run_search("tp3", 32'd7, 32'd9, 8'h05, 3);

      // Hash core silent -> timeout
      core_en = 1'b0;
      entry_12_in = '1; target_in = 8'h40; nonce_first = 32'd0; nonce_last = 32'd3;
      pulse_start();
      check("to_selector_up", hif.selector, 1);
      cyc = 0;
      while (!done && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      check("to_latency", cyc, 1 + TIMEOUT_CYCLES);
      check("to_timeout", timeout, 1);
      check("to_done", done, 1);
      check("to_found", found, 0);
      check("to_attempts", attempts, 0);
      check("to_selector", hif.selector, 0);

      // Reset mid-WAIT
      pulse_start();
      repeat (4) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_selector", hif.selector, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_timeout", timeout, 0);
      check("mid_rst_hash_out", hash_out, 0);
      check("mid_rst_target", hif.data_target, 0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 16; i++) hb[i] = 8'hC0;
      hb[2] = 8'h00;
      run_search("post_rst", 32'h20, 32'h24, 8'h01, 5);

      // Empty range: no selector pulse
      run_search("empty", 32'h10, 32'h0F, 8'h80, 5);

      // start while busy is ignored
      for (int i = 0; i < 16; i++) hb[i] = 8'hFF;
      hb[3] = 8'h02;
      core_lat = 20; core_en = 1'b1; hb_base = 32'd100;
      entry_12_in = 96'h1234; target_in = 8'h10; nonce_first = 32'd100; nonce_last = 32'd104;
      sel_rises = 0;
      pulse_start();
      repeat (2) @(negedge clk);
      entry_12_in = 96'hBEEF; target_in = 8'hFF; nonce_first = 32'hDEAD; nonce_last = 32'hFFFF;
      pulse_start();
      check("busy_start_nonce", hif.data_nonce, 32'd100);
      wait_done("busy_start", cyc);
      check("busy_start_found", found, 1);
      check("busy_start_nonce_out", nonce_out, 32'd103);
      check("busy_start_attempts", attempts, 4);
      check("busy_start_entry", hif.data_entry_12, 96'h1234);

      // Randomised sweeps, first one pinned at the top of the nonce space
      for (int k = 0; k < 10; k++) begin
         len = $urandom_range(0, 11);
         f   = $urandom;
         if (k == 0 || f > 32'hFFFF_FFFF - 32'(len)) f = 32'hFFFF_FFFF - 32'(len);
         l   = f + 32'(len);
         for (int i = 0; i < 16; i++) hb[i] = 8'($urandom);
         run_search($sformatf("rnd%0d", k), f, l, 8'($urandom_range(0, 60)), $urandom_range(1, 30));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
